layer_engine: RTL and testbench

//  Parametrised fully-connected layer core: NUM_OUTPUTS neurons, each holding NUM_INPUTS weights plus a bias.

---
 rtl/layer_pkg.sv | 35 +++
 rtl/layer_neuron.sv | 94 +++++++++
 rtl/layer_engine.sv | 131 +++++++++++++
 tb/tb_layer_engine.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_pkg.sv
// Shared types and helpers for the fully-connected layer engine.
//   state_t    : frame sequencing states (ACCUM, BIAS, ACT, HOLD)
//   ACT_*      : activation mode encodings for ACT_MODE
//   sat_trunc  : range check plus optional clamp of a shifted accumulator
package layer_pkg;

    typedef enum logic [1:0] {ACCUM, BIAS, ACT, HOLD} state_t;

    localparam logic ACT_IDENTITY = 1'b0;
    localparam logic ACT_RELU     = 1'b1;

    typedef struct packed {
        logic               ovf;
        logic signed [63:0] val;
    } sat_t;

    // r is already scaled back to integer units; width is the output word width.
    // The caller keeps val[width-1:0]. With sat_en=0 val is r unchanged, so
    // taking the low bits gives the wrap behaviour.
    function automatic sat_t sat_trunc(input logic signed [63:0] r,
                                       input int width,
                                       input logic sat_en);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_t s;
        hi    = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo    = -hi - 64'sd1;
        s.ovf = (r > hi) || (r < lo);
        s.val = r;
        if (sat_en && (r > hi)) s.val = hi;
        else if (sat_en && (r < lo)) s.val = lo;
        return s;
    endfunction

endpackage

// File: rtl/layer_neuron.sv
// One neuron of the layer: weight/bias register file, LANES-wide MAC,
// bias add, scale-back, saturate/wrap and optional ReLU.
//   wr_en/addr/wr_data : config write (addr NUM_INPUTS is the bias)
//   rd_data            : combinational read of register at addr (0 if invalid)
//   mac_en/beat/x      : accumulate one beat of LANES inputs
//   bias_en/act_en/clr : sequencing strobes from the top FSM
//   act_mode/sat_en    : frame-latched output options
//   y/ovf              : registered result and pre-ReLU overflow flag
module layer_neuron
    import layer_pkg::*;
#(
    parameter int NUM_INPUTS = 16,
    parameter int WIDTH      = 8,
    parameter int FRAC_BITS  = 5,
    parameter int LANES      = 2,
    parameter int AW         = 5,
    parameter int BW         = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [AW-1:0]               addr,
    input  logic [WIDTH-1:0]            wr_data,
    output logic [WIDTH-1:0]            rd_data,
    input  logic                        mac_en,
    input  logic [BW-1:0]               beat,
    input  logic [LANES-1:0][WIDTH-1:0] x,
    input  logic                        bias_en,
    input  logic                        act_en,
    input  logic                        clr,
    input  logic                        act_mode,
    input  logic                        sat_en,
    output logic [WIDTH-1:0]            y,
    output logic                        ovf
);

    localparam int ACC_W = 2 * WIDTH + $clog2(NUM_INPUTS);
    localparam int PW    = 2 * WIDTH;
    localparam logic [AW-1:0] BIAS_ADDR = AW'(NUM_INPUTS);

    logic signed [WIDTH-1:0] mem [NUM_INPUTS+1];
    logic signed [ACC_W-1:0] acc, mac_sum, bias_ext, r;
    logic [AW-1:0]           idx;
    sat_t                    st;
    logic [WIDTH-1:0]        res;
    logic                    unused_hi;

    assign rd_data  = (addr <= BIAS_ADDR) ? mem[addr] : '0;
    // Bias is aligned to the product scale (2*FRAC_BITS fraction bits).
    assign bias_ext = ACC_W'(mem[NUM_INPUTS]) <<< FRAC_BITS;

    always_comb begin
        mac_sum = '0;
        idx     = '0;
        for (int k = 0; k < LANES; k++) begin
            idx     = AW'(int'(beat) * LANES + k);
            mac_sum = mac_sum + ACC_W'(PW'(mem[idx]) * PW'($signed(x[k])));
        end
    end

    always_comb begin
        r   = acc >>> FRAC_BITS;
        st  = sat_trunc(64'(r), WIDTH, sat_en);
        res = st.val[WIDTH-1:0];
        if ((act_mode == ACT_RELU) && res[WIDTH-1]) res = '0;
    end

    assign unused_hi = ^st.val[63:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j <= NUM_INPUTS; j++) mem[j] <= '0;
        end else if (wr_en && (addr <= BIAS_ADDR)) begin
            mem[addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            y   <= '0;
            ovf <= 1'b0;
        end else begin
            if (clr)          acc <= '0;
            else if (mac_en)  acc <= acc + mac_sum;
            else if (bias_en) acc <= acc + bias_ext;
            if (act_en) begin
                y   <= res;
                ovf <= st.ovf;
            end
        end
    end

endmodule

// File: rtl/layer_engine.sv
// Fully-connected layer core: NUM_OUTPUTS neurons over NUM_INPUTS inputs,
// LANES inputs per beat, all outputs presented in parallel with a
// valid/ready handshake.
//   CFG_*      : weight/bias write (only between frames) and 1-cycle readback
//   ACT_MODE   : 0 identity, 1 ReLU (latched on the first beat)
//   SAT_EN     : 1 saturate, 0 wrap (latched on the first beat)
//   VALUES_IN/VALID_IN/READY   : input beat stream
//   VALUES_OUT/VALID_OUT/OUT_READY/OVERFLOW : result vector
module layer_engine
    import layer_pkg::*;
#(
    parameter int NUM_INPUTS  = 16,
    parameter int NUM_OUTPUTS = 8,
    parameter int WIDTH       = 8,
    parameter int FRAC_BITS   = 5,
    parameter int LANES       = 2
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            CFG_WE,
    input  logic [$clog2(NUM_OUTPUTS)-1:0]  CFG_SEL,
    input  logic [$clog2(NUM_INPUTS+1)-1:0] CFG_ADDR,
    input  logic [WIDTH-1:0]                CFG_WDATA,
    output logic [WIDTH-1:0]                CFG_RDATA,
    output logic                            CFG_ERR,
    input  logic                            ACT_MODE,
    input  logic                            SAT_EN,
    output logic                            READY,
    input  logic [LANES*WIDTH-1:0]          VALUES_IN,
    input  logic                            VALID_IN,
    output logic [NUM_OUTPUTS*WIDTH-1:0]    VALUES_OUT,
    output logic                            VALID_OUT,
    input  logic                            OUT_READY,
    output logic [NUM_OUTPUTS-1:0]          OVERFLOW
);

    localparam int SW    = $clog2(NUM_OUTPUTS);
    localparam int AW    = $clog2(NUM_INPUTS + 1);
    localparam int BEATS = NUM_INPUTS / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [AW-1:0] BIAS_ADDR = AW'(NUM_INPUTS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    state_t  state;
    logic [BW-1:0] beat;
    logic mode_q, sat_q;
    logic accept, addr_ok, wr_ok;
    logic [LANES-1:0][WIDTH-1:0]     x_in;
    logic [NUM_OUTPUTS-1:0][WIDTH-1:0] y_all;
    // Padded to a power of two so any CFG_SEL value indexes safely.
    logic [(1<<SW)-1:0][WIDTH-1:0]   rd_all;

    assign x_in       = VALUES_IN;
    assign VALUES_OUT = y_all;
    assign accept     = VALID_IN && READY;
    assign addr_ok    = (CFG_ADDR <= BIAS_ADDR);
    // Weights may only change while no frame is partially accumulated.
    assign wr_ok      = CFG_WE && (state == ACCUM) && (beat == '0) && addr_ok;

    for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_neuron
        layer_neuron #(
            .NUM_INPUTS(NUM_INPUTS), .WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS),
            .LANES(LANES), .AW(AW), .BW(BW)
        ) u_neuron (
            .clk     (CLK),
            .rst     (RST),
            .wr_en   (wr_ok && (CFG_SEL == SW'(i))),
            .addr    (CFG_ADDR),
            .wr_data (CFG_WDATA),
            .rd_data (rd_all[i]),
            .mac_en  (accept),
            .beat    (beat),
            .x       (x_in),
            .bias_en (state == BIAS),
            .act_en  (state == ACT),
            .clr     ((state == HOLD) && OUT_READY),
            .act_mode(mode_q),
            .sat_en  (sat_q),
            .y       (y_all[i]),
            .ovf     (OVERFLOW[i])
        );
    end

    for (genvar i = NUM_OUTPUTS; i < (1 << SW); i++) begin : g_pad
        assign rd_all[i] = '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ACCUM;
            beat      <= '0;
            READY     <= 1'b1;
            VALID_OUT <= 1'b0;
            mode_q    <= ACT_IDENTITY;
            sat_q     <= 1'b0;
            CFG_ERR   <= 1'b0;
            CFG_RDATA <= '0;
        end else begin
            CFG_ERR   <= CFG_WE && !wr_ok;
            CFG_RDATA <= addr_ok ? rd_all[CFG_SEL] : '0;
            case (state)
                ACCUM: if (accept) begin
                    if (beat == '0) begin
                        mode_q <= ACT_MODE;
                        sat_q  <= SAT_EN;
                    end
                    if (beat == LAST_BEAT) begin
                        beat  <= '0;
                        state <= BIAS;
                        READY <= 1'b0;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                BIAS: state <= ACT;
                ACT: begin
                    state     <= HOLD;
                    VALID_OUT <= 1'b1;
                end
                HOLD: if (OUT_READY) begin
                    state     <= ACCUM;
                    VALID_OUT <= 1'b0;
                    READY     <= 1'b1;
                    beat      <= '0;
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_engine.sv
module tb_layer_engine;

    localparam int NI = 16, NO = 8, W = 8, FB = 5, L = 2, NB = NI / L;

    logic           CLK = 1'b0, RST = 1'b1;
    logic           CFG_WE = 1'b0;
    logic [2:0]     CFG_SEL = '0;
    logic [4:0]     CFG_ADDR = '0;
    logic [W-1:0]   CFG_WDATA = '0, CFG_RDATA;
    logic           CFG_ERR;
    logic           ACT_MODE = 1'b0, SAT_EN = 1'b0, READY;
    logic [L*W-1:0] VALUES_IN = '0;
    logic           VALID_IN = 1'b0;
    logic [NO*W-1:0] VALUES_OUT;
    logic           VALID_OUT, OUT_READY = 1'b0;
    logic [NO-1:0]  OVERFLOW;

    always #5 CLK = ~CLK;

    layer_engine #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .WIDTH(W), .FRAC_BITS(FB), .LANES(L)) dut (
        .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_SEL(CFG_SEL), .CFG_ADDR(CFG_ADDR),
        .CFG_WDATA(CFG_WDATA), .CFG_RDATA(CFG_RDATA), .CFG_ERR(CFG_ERR),
        .ACT_MODE(ACT_MODE), .SAT_EN(SAT_EN), .READY(READY), .VALUES_IN(VALUES_IN),
        .VALID_IN(VALID_IN), .VALUES_OUT(VALUES_OUT), .VALID_OUT(VALID_OUT),
        .OUT_READY(OUT_READY), .OVERFLOW(OVERFLOW)
    );

    // reference state: the layer's registers and the current input vector
    byte             wt [NO][NI+1];
    byte             xin [NI];
    logic [NO*W-1:0] exp_y;
    logic [NO-1:0]   exp_ovf;
    int              n_chk = 0, n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // Dot product in plain integers, bias scaled to the product fraction,
    // floor division back to the word scale, then range handling and ReLU.
    task automatic model(input bit act, input bit sat);
        for (int i = 0; i < NO; i++) begin
            int  acc;
            int  r;
            int  o;
            byte ob;
            acc = 0;
            for (int j = 0; j < NI; j++) acc += int'(wt[i][j]) * int'(xin[j]);
            acc += int'(wt[i][NI]) * (1 << FB);
            r = acc >>> FB;
            exp_ovf[i] = (r > 127) || (r < -128);
            o = r;
            if (sat && r > 127) o = 127;
            else if (sat && r < -128) o = -128;
            ob = byte'(o);
            if (act && ob < 0) ob = 0;
            exp_y[i*W +: W] = ob;
        end
    endtask

    task automatic cfg_write(input int sel, input int addr, input byte d, input bit exp_err);
        CFG_WE = 1'b1; CFG_SEL = 3'(sel); CFG_ADDR = 5'(addr); CFG_WDATA = d;
        step;
        CFG_WE = 1'b0;
        check("cfg_err", CFG_ERR, exp_err);
        if (!exp_err && addr <= NI) wt[sel][addr] = d;
    endtask

    task automatic check_read(input string tag, input int sel, input int addr);
        logic [7:0] e;
        CFG_SEL = 3'(sel); CFG_ADDR = 5'(addr);
        step;
        e = (addr <= NI) ? wt[sel][addr] : 8'h00;
        check(tag, CFG_RDATA, e);
    endtask

    task automatic load_uniform(input byte w, input byte b);
        for (int s = 0; s < NO; s++)
            for (int a = 0; a <= NI; a++) cfg_write(s, a, (a == NI) ? b : w, 1'b0);
    endtask

    task automatic load_rand(input int lo, input int hi);
        for (int s = 0; s < NO; s++)
            for (int a = 0; a <= NI; a++) cfg_write(s, a, byte'(int'($urandom_range(0, hi - lo)) + lo), 1'b0);
    endtask

    task automatic rand_x(input int lo, input int hi);
        for (int j = 0; j < NI; j++) xin[j] = byte'(int'($urandom_range(0, hi - lo)) + lo);
    endtask

    task automatic send_beats(input int from, input int to, input bit act, input bit sat, input bit gaps);
        for (int b = from; b < to; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                VALID_IN = 1'b0;
                step;
            end
            VALUES_IN = {xin[2*b+1], xin[2*b]};
            VALID_IN  = 1'b1;
            if (b == 0) begin
                ACT_MODE = act; SAT_EN = sat;
            end else begin
                ACT_MODE = 1'($urandom); SAT_EN = 1'($urandom);
            end
            step;
        end
        VALID_IN = 1'b0;
        ACT_MODE = 1'($urandom); SAT_EN = 1'($urandom);
    endtask

    task automatic finish_frame(input bit act, input bit sat);
        int lat;
        model(act, sat);
        lat = 0;
        while (!VALID_OUT && lat < 10) begin
            step;
            lat++;
        end
        check("latency", lat, 2);
        check("values", VALUES_OUT, exp_y);
        check("overflow", OVERFLOW, exp_ovf);
        check("ready_hold", READY, 1'b0);
    endtask

    task automatic consume;
        OUT_READY = 1'b1;
        step;
        OUT_READY = 1'b0;
        check("consumed_valid", VALID_OUT, 1'b0);
        check("consumed_ready", READY, 1'b1);
    endtask

    task automatic frame(input bit act, input bit sat, input bit gaps);
        send_beats(0, NB, act, sat, gaps);
        finish_frame(act, sat);
        consume;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int s = 0; s < NO; s++) for (int a = 0; a <= NI; a++) wt[s][a] = 0;
        step; step;
        RST = 1'b0;
        step;
        check("rst_ready", READY, 1'b1);
        check("rst_valid", VALID_OUT, 1'b0);
        check("rst_values", VALUES_OUT, '0);
        check("rst_ovf", OVERFLOW, '0);
        check("rst_rdata", CFG_RDATA, '0);
        check("rst_err", CFG_ERR, 1'b0);

        // register file: write pattern, read everything back
        for (int s = 0; s < NO; s++)
            for (int a = 0; a <= NI; a++) cfg_write(s, a, byte'((s * 17 + a) % 256), 1'b0);
        for (int s = 0; s < NO; s++)
            for (int a = 0; a <= NI; a++) check_read("readback", s, a);
        cfg_write(3, 20, 8'h55, 1'b1);
        check_read("bad_addr_read", 3, 20);
        check_read("bias_after_bad", 3, NI);

        // 1.0 weights, 0.125 inputs
        load_uniform(8'h20, 8'h00);
        for (int j = 0; j < NI; j++) xin[j] = 8'h04;
        send_beats(0, NB, 1'b0, 1'b0, 1'b0);
        finish_frame(1'b0, 1'b0);
        check("t2_const", VALUES_OUT, {NO{8'h40}});
        check("t2_ovf", OVERFLOW, '0);
        consume;

        // negative bias with -0.25 inputs, ReLU on then off
        load_uniform(8'h20, 8'hC0);
        for (int j = 0; j < NI; j++) xin[j] = 8'hF8;
        send_beats(0, NB, 1'b1, 1'b1, 1'b0);
        finish_frame(1'b1, 1'b1);
        check("t3_relu", VALUES_OUT, '0);
        consume;
        frame(1'b0, 1'b1, 1'b0);
        frame(1'b0, 1'b0, 1'b0);

        // overflow: saturate, wrap, negative saturate
        load_uniform(8'h20, 8'h00);
        for (int j = 0; j < NI; j++) xin[j] = 8'h20;
        send_beats(0, NB, 1'b0, 1'b1, 1'b0);
        finish_frame(1'b0, 1'b1);
        check("t4_sat", VALUES_OUT, {NO{8'h7F}});
        check("t4_sat_ovf", OVERFLOW, {NO{1'b1}});
        consume;
        send_beats(0, NB, 1'b0, 1'b0, 1'b0);
        finish_frame(1'b0, 1'b0);
        check("t4_wrap", VALUES_OUT, '0);
        check("t4_wrap_ovf", OVERFLOW, {NO{1'b1}});
        consume;
        for (int j = 0; j < NI; j++) xin[j] = 8'hE0;
        send_beats(0, NB, 1'b0, 1'b1, 1'b0);
        finish_frame(1'b0, 1'b1);
        check("t4_negsat", VALUES_OUT, {NO{8'h80}});
        consume;

        // backpressure in HOLD
        load_rand(-16, 15);
        rand_x(-128, 127);
        send_beats(0, NB, 1'b0, 1'b1, 1'b1);
        finish_frame(1'b0, 1'b1);
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin
                cfg_write(2, 4, ~wt[2][4], 1'b1);
                check_read("hold_readback", 2, 4);
            end else begin
                step;
            end
            check("hold_valid", VALID_OUT, 1'b1);
            check("hold_values", VALUES_OUT, exp_y);
            check("hold_ovf", OVERFLOW, exp_ovf);
            check("hold_ready", READY, 1'b0);
        end
        rand_x(-128, 127);
        VALUES_IN = {xin[1], xin[0]};
        VALID_IN  = 1'b1;
        ACT_MODE  = 1'b1; SAT_EN = 1'b0;
        OUT_READY = 1'b1;
        step;
        OUT_READY = 1'b0;
        check("release_valid", VALID_OUT, 1'b0);
        check("release_ready", READY, 1'b1);
        step;
        send_beats(1, NB, 1'b1, 1'b0, 1'b0);
        finish_frame(1'b1, 1'b0);
        consume;

        // reset mid-frame
        rand_x(-128, 127);
        send_beats(0, 3, 1'b0, 1'b1, 1'b0);
        RST = 1'b1;
        step;
        RST = 1'b0;
        check("mrst_ready", READY, 1'b1);
        check("mrst_valid", VALID_OUT, 1'b0);
        check("mrst_values", VALUES_OUT, '0);
        for (int s = 0; s < NO; s++) for (int a = 0; a <= NI; a++) wt[s][a] = 0;
        for (int s = 0; s < NO; s++) for (int a = 0; a <= NI; a++) check_read("mrst_reg", s, a);
        load_rand(-40, 40);
        rand_x(-128, 127);
        frame(1'b0, 1'b1, 1'b1);

        // random frames
        for (int f = 0; f < 6; f++) begin
            if (f % 2 == 0) load_rand(-128, 127);
            else load_rand(-12, 12);
            rand_x(-128, 127);
            frame(1'($urandom), 1'($urandom), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
